// File: rtl/dyn_array_ctrl.sv
// Run-time resizable DEPTH x WIDTH array with zero-fill on growth and bounds-checked access.
// Optional macro DYN_ARRAY_ERRCNT_EN adds a saturating error-response counter (err_cnt).
module dyn_array_ctrl #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int SW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [SW-1:0]    cmd_size,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [WIDTH-1:0] cmd_wdata,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_data,
  output logic [SW-1:0]    size,
`ifdef DYN_ARRAY_ERRCNT_EN
  output logic [7:0]       err_cnt,
`endif
  output logic             busy
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
  // Every accepted command yields exactly one single-cycle rsp_valid pulse; no backpressure.

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  localparam logic [2:0]    OP_ALLOC  = 3'd0;
  localparam logic [2:0]    OP_RESIZE = 3'd1;
  localparam logic [2:0]    OP_DELETE = 3'd2;
  localparam logic [2:0]    OP_WRITE  = 3'd3;
  localparam logic [2:0]    OP_READ   = 3'd4;
  localparam logic [SW-1:0] DEPTH_SZ  = SW'(DEPTH);

  state_t             state_q;
  logic [SW-1:0]      size_q;
  logic [SW-1:0]      fill_ptr_q;
  logic [SW-1:0]      target_q;
  logic               rsp_valid_q;
  logic               rsp_err_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  logic               accept;
  logic               addr_ok;
  logic               mem_we_d;
  logic [AW-1:0]      mem_waddr_d;
  logic [WIDTH-1:0]   mem_wdata_d;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == FILL);
  assign accept    = cmd_valid && cmd_ready;
  assign addr_ok   = (SW'(cmd_addr) < size_q);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign size      = size_q;

  // Fill zeroing and WRITE share the single storage write port; they never overlap.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = cmd_addr;
    mem_wdata_d = cmd_wdata;
    if (state_q == FILL) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = fill_ptr_q[AW-1:0];
      mem_wdata_d = '0;
    end else if (accept && cmd_op == OP_WRITE && addr_ok) begin
      mem_we_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_d) mem_q[mem_waddr_d] <= mem_wdata_d;
  end

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      state_q     <= IDLE;
      size_q      <= '0;
      fill_ptr_q  <= '0;
      target_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            rsp_valid_q <= 1'b1;
            case (cmd_op)
              OP_ALLOC: begin
                if (cmd_size > DEPTH_SZ) begin
                  rsp_err_q <= 1'b1;
                end else if (cmd_size == '0) begin
                  size_q <= '0;
                end else begin
                  rsp_valid_q <= 1'b0;
                  fill_ptr_q  <= '0;
                  target_q    <= cmd_size;
                  state_q     <= FILL;
                end
              end
              OP_RESIZE: begin
                if (cmd_size > DEPTH_SZ) begin
                  rsp_err_q <= 1'b1;
                end else if (cmd_size <= size_q) begin
                  size_q <= cmd_size;
                end else begin
                  // Growth zeroes only the newly exposed tail; 0..size-1 are kept.
                  rsp_valid_q <= 1'b0;
                  fill_ptr_q  <= size_q;
                  target_q    <= cmd_size;
                  state_q     <= FILL;
                end
              end
              OP_DELETE: size_q <= '0;
              OP_WRITE:  rsp_err_q <= !addr_ok;
              OP_READ: begin
                if (addr_ok) rsp_data_q <= mem_q[cmd_addr];
                else         rsp_err_q  <= 1'b1;
              end
              default: rsp_err_q <= 1'b1;
            endcase
          end
        end
        FILL: begin
          if (fill_ptr_q == target_q - SW'(1)) begin
            size_q      <= target_q;
            rsp_valid_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            fill_ptr_q <= fill_ptr_q + SW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DYN_ARRAY_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      err_cnt_q <= '0;
    end else if (accept && cmd_op == OP_ALLOC) begin
      err_cnt_q <= '0;
    end else if (rsp_valid_q && rsp_err_q && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_dyn_array_ctrl.sv
// Directed bench for dyn_array_ctrl: latency, zero-fill, preserve, bounds and reset-abort.
// Covers err_cnt as well when built with DYN_ARRAY_ERRCNT_EN.
module tb_dyn_array_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int SW    = 5;

  logic             clk;
  logic             nreset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [SW-1:0]    cmd_size;
  logic [AW-1:0]    cmd_addr;
  logic [WIDTH-1:0] cmd_wdata;
  logic             rsp_valid;
  logic             rsp_err;
  logic [WIDTH-1:0] rsp_data;
  logic [SW-1:0]    size;
  logic             busy;
`ifdef DYN_ARRAY_ERRCNT_EN
  logic [7:0]       err_cnt;
`endif

  int total = 0;
  int bad   = 0;

  dyn_array_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_size  (cmd_size),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .size      (size),
`ifdef DYN_ARRAY_ERRCNT_EN
    .err_cnt   (err_cnt),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: presents one command for one edge, then waits (bounded) for its response.
  // lat = 1 means rsp_valid is seen right after the accepting edge.
  task automatic issue(input logic [2:0] op, input int sz, input int addr, input int wd,
                       output int lat, output int bcnt, output logic err,
                       output logic [WIDTH-1:0] data);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_size  = SW'(sz);
    cmd_addr  = AW'(addr);
    cmd_wdata = WIDTH'(wd);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (!rsp_valid && lat < 64) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    err  = rsp_err;
    data = rsp_data;
    total++;
    if (!rsp_valid) begin
      bad++;
      $display("FAIL rsp_timeout op=%0d: got no rsp_valid within %0d cycles, need one", op, lat);
    end
  endtask

  task automatic test_reset();
    if (size !== 5'd0) begin bad++; $display("FAIL reset_size: got %0d need 0", size); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b need 0", busy); end
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b need 0", rsp_valid); end
    if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got %b need 0", rsp_err); end
    if (rsp_data !== 8'h00) begin bad++; $display("FAIL reset_rsp_data: got %h need 00", rsp_data); end
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b need 1", cmd_ready); end
    total += 6;
  endtask

  task automatic test_alloc_write();
    int lat, bc;
    logic e;
    logic [WIDTH-1:0] d;
    issue(3'd0, 4, 0, 0, lat, bc, e, d);
    if (lat !== 5) begin bad++; $display("FAIL alloc4_lat: got %0d need 5", lat); end
    if (bc !== 4) begin bad++; $display("FAIL alloc4_busy: got %0d need 4", bc); end
    if (e !== 1'b0) begin bad++; $display("FAIL alloc4_err: got %b need 0", e); end
    if (size !== 5'd4) begin bad++; $display("FAIL alloc4_size: got %0d need 4", size); end
    total += 4;
    for (int i = 0; i < 4; i++) begin
      issue(3'd3, 0, i, i, lat, bc, e, d);
      if (lat !== 1 || e !== 1'b0) begin
        bad++; $display("FAIL write_%0d: got lat=%0d err=%b need lat=1 err=0", i, lat, e);
      end
      total++;
    end
  endtask

  task automatic test_grow_preserve();
    int lat, bc;
    logic e;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] exp_d [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
    issue(3'd1, 8, 0, 0, lat, bc, e, d);
    if (bc !== 4) begin bad++; $display("FAIL grow_busy: got %0d need 4", bc); end
    if (lat !== 5) begin bad++; $display("FAIL grow_lat: got %0d need 5", lat); end
    if (size !== 5'd8) begin bad++; $display("FAIL grow_size: got %0d need 8", size); end
    total += 3;
    for (int i = 0; i < 8; i++) begin
      issue(3'd4, 0, i, 0, lat, bc, e, d);
      if (d !== exp_d[i] || e !== 1'b0) begin
        bad++; $display("FAIL grow_read_%0d: got data=%h err=%b need data=%h err=0", i, d, e, exp_d[i]);
      end
      total++;
    end
  endtask

  task automatic test_delete();
    int lat, bc;
    logic e;
    logic [WIDTH-1:0] d;
    issue(3'd2, 0, 0, 0, lat, bc, e, d);
    if (size !== 5'd0 || lat !== 1) begin
      bad++; $display("FAIL delete: got size=%0d lat=%0d need size=0 lat=1", size, lat);
    end
    issue(3'd4, 0, 0, 0, lat, bc, e, d);
    if (e !== 1'b1 || d !== 8'h00) begin
      bad++; $display("FAIL delete_read: got err=%b data=%h need err=1 data=00", e, d);
    end
    total += 2;
  endtask

  task automatic test_bounds();
    int lat, bc;
    logic e;
    logic [WIDTH-1:0] d;
    issue(3'd0, 17, 0, 0, lat, bc, e, d);
    if (e !== 1'b1 || lat !== 1 || size !== 5'd0) begin
      bad++; $display("FAIL alloc17: got err=%b lat=%0d size=%0d need err=1 lat=1 size=0", e, lat, size);
    end
    issue(3'd0, 16, 0, 0, lat, bc, e, d);
    if (e !== 1'b0 || lat !== 17 || size !== 5'd16) begin
      bad++; $display("FAIL alloc16: got err=%b lat=%0d size=%0d need err=0 lat=17 size=16", e, lat, size);
    end
    issue(3'd3, 0, 15, 8'hA5, lat, bc, e, d);
    if (e !== 1'b0) begin bad++; $display("FAIL write15_err: got %b need 0", e); end
    issue(3'd4, 0, 15, 0, lat, bc, e, d);
    if (e !== 1'b0 || d !== 8'hA5) begin
      bad++; $display("FAIL read15: got err=%b data=%h need err=0 data=a5", e, d);
    end
    issue(3'd4, 0, 7, 0, lat, bc, e, d);
    if (e !== 1'b0 || d !== 8'h00) begin
      bad++; $display("FAIL read7_zeroed: got err=%b data=%h need err=0 data=00", e, d);
    end
    issue(3'd6, 0, 0, 0, lat, bc, e, d);
    if (e !== 1'b1 || d !== 8'h00 || size !== 5'd16) begin
      bad++; $display("FAIL op6: got err=%b data=%h size=%0d need err=1 data=00 size=16", e, d, size);
    end
    issue(3'd1, 20, 0, 0, lat, bc, e, d);
    if (e !== 1'b1 || size !== 5'd16) begin
      bad++; $display("FAIL resize20: got err=%b size=%0d need err=1 size=16", e, size);
    end
    total += 7;
  endtask

  task automatic test_shrink_regrow();
    int lat, bc;
    logic e;
    logic [WIDTH-1:0] d;
    issue(3'd0, 4, 0, 0, lat, bc, e, d);
    for (int i = 0; i < 4; i++) issue(3'd3, 0, i, 8'hFF, lat, bc, e, d);
    issue(3'd1, 2, 0, 0, lat, bc, e, d);
    if (lat !== 1 || size !== 5'd2) begin
      bad++; $display("FAIL shrink2: got lat=%0d size=%0d need lat=1 size=2", lat, size);
    end
    issue(3'd4, 0, 2, 0, lat, bc, e, d);
    if (e !== 1'b1 || d !== 8'h00) begin
      bad++; $display("FAIL read_at_size: got err=%b data=%h need err=1 data=00", e, d);
    end
    issue(3'd3, 0, 2, 8'h55, lat, bc, e, d);
    if (e !== 1'b1) begin bad++; $display("FAIL write_at_size: got err=%b need 1", e); end
    issue(3'd1, 4, 0, 0, lat, bc, e, d);
    if (lat !== 3 || bc !== 2 || size !== 5'd4) begin
      bad++; $display("FAIL regrow4: got lat=%0d busy=%0d size=%0d need lat=3 busy=2 size=4", lat, bc, size);
    end
    issue(3'd4, 0, 2, 0, lat, bc, e, d);
    if (e !== 1'b0 || d !== 8'h00) begin
      bad++; $display("FAIL regrow_read2: got err=%b data=%h need err=0 data=00", e, d);
    end
    issue(3'd4, 0, 1, 0, lat, bc, e, d);
    if (e !== 1'b0 || d !== 8'hFF) begin
      bad++; $display("FAIL regrow_read1: got err=%b data=%h need err=0 data=ff", e, d);
    end
    total += 6;
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic e;
    logic [WIDTH-1:0] d;
    issue(3'd4, 0, 0, 0, lat, bc, e, d);
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL ready_in_rsp: got %b need 1", cmd_ready); end
    issue(3'd4, 0, 1, 0, lat, bc, e, d);
    if (lat !== 1 || d !== 8'hFF) begin
      bad++; $display("FAIL b2b_read1: got lat=%0d data=%h need lat=1 data=ff", lat, d);
    end
    @(posedge clk);
    #1;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rsp_pulse_width: got %b need 0", rsp_valid); end
    total += 3;
  endtask

  task automatic test_reset_mid_fill();
    int lat, bc;
    logic e;
    logic [WIDTH-1:0] d;
    int seen;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    cmd_size  = 5'd16;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
    end
    if (busy !== 1'b1 || cmd_ready !== 1'b0 || size !== 5'd4) begin
      bad++; $display("FAIL mid_fill: got busy=%b ready=%b size=%0d need busy=1 ready=0 size=4", busy, cmd_ready, size);
    end
    nreset = 1'b1;
    #1;
    if (size !== 5'd0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL fill_abort: got size=%0d busy=%b rsp=%b need 0 0 0", size, busy, rsp_valid);
    end
    @(negedge clk);
    nreset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid || busy) seen++;
    end
    if (seen !== 0) begin bad++; $display("FAIL abort_quiet: got %0d active cycles need 0", seen); end
    total += 3;
`ifdef DYN_ARRAY_ERRCNT_EN
    if (err_cnt !== 8'd0) begin bad++; $display("FAIL errcnt_reset: got %0d need 0", err_cnt); end
    for (int i = 0; i < 3; i++) issue(3'd4, 0, i, 0, lat, bc, e, d);
    @(posedge clk);
    #1;
    if (err_cnt !== 8'd3) begin bad++; $display("FAIL errcnt_3: got %0d need 3", err_cnt); end
    issue(3'd0, 2, 0, 0, lat, bc, e, d);
    if (err_cnt !== 8'd0) begin bad++; $display("FAIL errcnt_alloc_clr: got %0d need 0", err_cnt); end
    total += 3;
`else
    issue(3'd4, 0, 0, 0, lat, bc, e, d);
    if (e !== 1'b1) begin bad++; $display("FAIL post_reset_read: got err=%b need 1", e); end
    total++;
`endif
  endtask

  initial begin
    nreset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_size  = '0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    nreset = 1'b0;
    test_alloc_write();
    test_grow_preserve();
    test_delete();
    test_bounds();
    test_shrink_regrow();
    test_back_to_back();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
